// File: rtl/n_bit_serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// n_bit_serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: the default operand
//   width and the FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused and
//   steers back to IDLE).
// ----------------------------------------------------------------------------
package n_bit_serial_subtractor_pkg;

    localparam int N_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : n_bit_serial_subtractor_pkg

// File: rtl/n_bit_serial_subtractor_fs.sv
// ----------------------------------------------------------------------------
// full_subtractor
//   Single-bit full subtractor cell, pure combinational: d = a - b - bin.
//   Companion of the full_adder cell used by the ripple-carry adder.
// Ports:
//   i_a    minuend bit
//   i_b    subtrahend bit
//   i_bin  borrow-in
//   o_d    difference bit
//   o_bout borrow-out
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule : full_subtractor

// File: rtl/n_bit_serial_subtractor.sv
// ----------------------------------------------------------------------------
// n_bit_serial_subtractor
//   Multi-cycle bit-serial subtractor: diff = a - b - bin (mod 2^N), computed
//   LSB-first with one full_subtractor cell, one bit per clock.
//   Operands accepted on edge k give out_valid after edge k+N.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready is high only in IDLE, out_valid only in DONE. The
//   result stays stable in DONE for as long as out_ready is low; in_valid
//   outside IDLE is ignored, never queued.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set valid
//   in_ready   block can accept operands
//   a, b       minuend / subtrahend (N bits)
//   bin        borrow-in
//   out_valid  result valid
//   out_ready  consumer accepts result
//   diff       a - b - bin mod 2^N
//   bout       unsigned borrow-out
//   ovf        signed two's-complement overflow
//   dbg_state  current FSM state (debug visibility)
// ----------------------------------------------------------------------------
module n_bit_serial_subtractor
    import n_bit_serial_subtractor_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic [1:0]   dbg_state
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t          r_state;
    logic [N-1:0]    r_sa;
    logic [N-1:0]    r_sb;
    logic [N-1:0]    r_diff;
    logic [CW-1:0]   r_cnt;
    logic            r_br;
    logic            r_am;
    logic            r_bm;
    logic            r_bout;
    logic            r_ovf;

    logic            w_d;
    logic            w_bnext;

    full_subtractor u_fs (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_bin  (r_br),
        .o_d    (w_d),
        .o_bout (w_bnext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_am    <= 1'b0;
            r_bm    <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= bin;
                        // Original MSBs kept for the overflow decision; the
                        // shift registers lose them after the first bit.
                        r_am    <= a[N-1];
                        r_bm    <= b[N-1];
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_sa   <= r_sa >> 1;
                    r_sb   <= r_sb >> 1;
                    r_diff <= {w_d, r_diff[N-1:1]};
                    r_br   <= w_bnext;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_bout  <= w_bnext;
                        // Operands of different sign, result sign differs
                        // from the minuend's sign.
                        r_ovf   <= (r_am ^ r_bm) & (r_am ^ w_d);
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule : n_bit_serial_subtractor

// File: tb/tb_n_bit_serial_subtractor.sv
module tb_n_bit_serial_subtractor;

  localparam int N = 16;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected results, packed as {bout, ovf, diff}.
  logic [N+1:0] exp_q[$];

  vec_t vecs[9];

  n_bit_serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: integer arithmetic, not bit-serial.
  function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic mbin);
    logic [N:0] u;
    int         s;
    logic       o;
    u = {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mbin};
    s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    o = (s > ((1 << (N - 1)) - 1)) || (s < -(1 << (N - 1)));
    return {u[N], o, u[N-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents an operand set and returns 1 time unit after the accept edge.
  task automatic send(input logic [N-1:0] a_i, input logic [N-1:0] b_i, input logic bin_i);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("send_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = a_i;
    b        = b_i;
    bin      = bin_i;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called 1 time unit after the accept edge: checks latency, result,
  // stability under 'stall' cycles of backpressure, then handshakes.
  task automatic collect(input int stall);
    logic [N+1:0] e;
    for (int i = 1; i < N; i++) @(posedge clk);
    #1;
    chk("lat_early", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("diff", {16'b0, diff}, {16'b0, e[N-1:0]});
    chk("bout", {31'b0, bout}, {31'b0, e[N+1]});
    chk("ovf",  {31'b0, ovf},  {31'b0, e[N]});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_diff", {16'b0, diff}, {16'b0, e[N-1:0]});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_diff",      {16'b0, diff},      32'd0);
    chk("rst_bout",      {31'b0, bout},      32'd0);
    chk("rst_ovf",       {31'b0, ovf},       32'd0);
    chk("rst_state",     {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].bin);
      exp_q.push_back({vecs[i].bout, vecs[i].ovf, vecs[i].diff});
      collect(i % 3);
    end

    // Backpressure and ignored in_valid pulses
    send(16'h1234, 16'h0234, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 16'h1000});
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("run_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0000;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    begin
      logic [N+1:0] e;
      e = exp_q.pop_front();
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        in_valid  = (j == 2);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
        chk("bp_diff",      {16'b0, diff},      {16'b0, e[N-1:0]});
        chk("bp_bout",      {31'b0, bout},      {31'b0, e[N+1]});
        chk("bp_ovf",       {31'b0, ovf},       {31'b0, e[N]});
      end
    end
    // Handshake with in_valid high: must not be accepted on the same edge.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h0005;
    b         = 16'h0003;
    bin       = 1'b0;
    @(posedge clk);
    #1;
    chk("done_no_accept_ready", {31'b0, in_ready},  32'd1);
    chk("done_no_accept_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 16'h0002});
    chk("next_accepted", {31'b0, in_ready}, 32'd0);
    collect(0);

    // Asynchronous reset mid-operation after bit 7
    send(16'hFFFF, 16'h0000, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("partial_diff", {16'b0, diff}, 32'h0000FF00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("arst_diff",      {16'b0, diff},      32'd0);
    chk("arst_bout",      {31'b0, bout},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h8000, 16'h0001, 1'b0);
    exp_q.push_back({1'b0, 1'b1, 16'h7FFF});
    collect(1);

    // Random regression against the integer model
    for (int k = 0; k < 1000; k++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic         rbin;
      ra   = N'($urandom);
      rb   = N'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if (k % 50 == 0) ra = 16'h8000;
      if (k % 70 == 0) rb = 16'h7FFF;
      send(ra, rb, rbin);
      exp_q.push_back(model(ra, rb, rbin));
      collect(int'($urandom_range(0, 3)));
    end

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_n_bit_serial_subtractor
